// File: rtl/video_ddr_write_ctrl_pkg.sv
// video_ddr_wr_pkg: shared FSM states, AXI encodings and beat-size helper for the DDR write sequencer
package video_ddr_wr_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, ADDR, DATA, RESP} state_e;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  function automatic int beat_size_log2(input int dwidth);
    return $clog2(dwidth / 8);
  endfunction
endpackage

// File: rtl/video_ddr_write_ctrl_if.sv
// video_ddr_write_ctrl_if: AXI4 write-only channel bundle (AW, W, B) between sequencer and interconnect
interface video_ddr_write_ctrl_if #(
  parameter int DWIDTH = 512,
  parameter int AWIDTH = 32
);
  logic [AWIDTH-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/video_ddr_write_ctrl_skid_buf.sv
// ddr_wr_skid_buf: two-entry FIFO decoupling the one-cycle FIFO read latency from W-channel backpressure
module ddr_wr_skid_buf #(
  parameter int DWIDTH = 512
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic [1:0]        occ_o
);
  logic [1:0][DWIDTH-1:0] mem_q, mem_d;
  logic                   wp_q, wp_d, rp_q, rp_d;
  logic [1:0]             cnt_q, cnt_d;
  // storage and pointers; cleared asynchronously so wvalid drops at once
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // circular write/read with simultaneous push and pop allowed
  always_comb begin
    mem_d       = mem_q;
    mem_d[wp_q] = push_i ? din_i : mem_q[wp_q];
    wp_d        = wp_q ^ push_i;
    rp_d        = rp_q ^ pop_i;
    cnt_d       = cnt_q + 2'(push_i) - 2'(pop_i);
    dout_o      = mem_q[rp_q];
    occ_o       = cnt_q;
  end
endmodule

// File: rtl/video_ddr_write_ctrl.sv
// video_ddr_write_ctrl: drains the video FIFO into AXI4 INCR bursts, flushing a short burst at frame end
module video_ddr_write_ctrl
  import video_ddr_wr_pkg::*;
#(
  parameter int g_VIDEO_FIFO_AWIDTH = 12,
  parameter int g_DDR_AXI_DWIDTH    = 512,
  parameter int g_DDR_AXI_AWIDTH    = 32,
  parameter int g_BURST_LEN         = 16
) (
  input  logic                           rclk_i,
  input  logic                           rstn_i,
  input  logic                           frame_start_i,
  input  logic                           frame_end_i,
  input  logic [g_DDR_AXI_AWIDTH-1:0]    frame_base_addr_i,
  input  logic [g_VIDEO_FIFO_AWIDTH-1:0] fifo_rdata_count_i,
  input  logic                           fifo_rempty_i,
  output logic                           fifo_ren_o,
  input  logic [g_DDR_AXI_DWIDTH-1:0]    fifo_rdata_i,
  input  logic                           fifo_rdata_rdy_i,
  video_ddr_write_ctrl_if.master         axi,
  output logic                           busy_o,
  output logic                           frame_done_o,
  output logic                           bresp_err_o
);
  localparam int AW = g_DDR_AXI_AWIDTH;
  localparam int BPB_LOG2 = beat_size_log2(g_DDR_AXI_DWIDTH);
  localparam logic [8:0] LEN_FULL = 9'(g_BURST_LEN);
  localparam logic [g_VIDEO_FIFO_AWIDTH-1:0] CNT_FULL = g_VIDEO_FIFO_AWIDTH'(g_BURST_LEN);
  state_e                      state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [8:0]                  len_q, len_d, beat_q, beat_d, fetch_q, fetch_d;
  logic [1:0]                  settle_q, settle_d, inflight_q, inflight_d, occ;
  logic                        eof_q, eof_d, err_q, err_d, done_q, done_d, ren, pop;
  logic [g_DDR_AXI_DWIDTH-1:0] head;
  ddr_wr_skid_buf #(.DWIDTH(g_DDR_AXI_DWIDTH)) u_skid (
    .clk_i  (rclk_i),
    .rstn_i (rstn_i),
    .push_i (fifo_rdata_rdy_i),
    .din_i  (fifo_rdata_i),
    .pop_i  (pop),
    .dout_o (head),
    .occ_o  (occ)
  );
  // state register and per-burst bookkeeping
  always_ff @(posedge rclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= 9'd0;
      beat_q     <= 9'd0;
      fetch_q    <= 9'd0;
      settle_q   <= 2'd0;
      inflight_q <= 2'd0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      fetch_q    <= fetch_d;
      settle_q   <= settle_d;
      inflight_q <= inflight_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end
  // next state; reads are throttled so buffered plus in-flight words never exceed two
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    settle_d   = settle_q;
    eof_d      = eof_q | (frame_end_i & (state_q != IDLE));
    err_d      = err_q;
    done_d     = 1'b0;
    ren        = (state_q == DATA) && (fetch_q != 9'd0) && (({1'b0, occ} + {1'b0, inflight_q}) < 3'd2) && !fifo_rempty_i;
    pop        = (occ != 2'd0) && axi.wready;
    inflight_d = inflight_q + 2'(ren) - 2'(fifo_rdata_rdy_i);
    fetch_d    = fetch_q - 9'(ren);
    case (state_q)
      IDLE: if (frame_start_i) begin
        state_d  = WAIT_DATA;
        addr_d   = frame_base_addr_i;
        eof_d    = 1'b0;
        err_d    = 1'b0;
        settle_d = 2'd0;
      end
      WAIT_DATA: begin
        settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        if (settle_q == 2'd2) begin
          if (fifo_rdata_count_i >= CNT_FULL) begin
            len_d   = LEN_FULL;
            state_d = ADDR;
          end else if (eof_q && fifo_rdata_count_i != '0) begin
            len_d   = 9'(fifo_rdata_count_i);
            state_d = ADDR;
          end else if (eof_q && fifo_rempty_i) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ADDR: if (axi.awready) begin
        state_d = DATA;
        fetch_d = len_q;
        beat_d  = 9'd0;
      end
      DATA: if (pop) begin
        beat_d  = beat_q + 9'd1;
        state_d = (beat_q == len_q - 9'd1) ? RESP : DATA;
      end
      RESP: if (axi.bvalid) begin
        addr_d   = addr_q + (AW'(len_q) << BPB_LOG2);
        err_d    = err_q | (axi.bresp != RESP_OKAY);
        settle_d = 2'd0;
        state_d  = WAIT_DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  // AXI and status outputs decoded from state and buffer occupancy
  always_comb begin
    axi.awaddr   = addr_q;
    axi.awlen    = (state_q == ADDR) ? 8'(len_q - 9'd1) : 8'd0;
    axi.awsize   = 3'(BPB_LOG2);
    axi.awburst  = BURST_INCR;
    axi.awvalid  = state_q == ADDR;
    axi.wdata    = head;
    axi.wstrb    = '1;
    axi.wvalid   = occ != 2'd0;
    axi.wlast    = (occ != 2'd0) && (state_q == DATA) && (beat_q == len_q - 9'd1);
    axi.bready   = state_q == RESP;
    fifo_ren_o   = ren;
    busy_o       = state_q != IDLE;
    frame_done_o = done_q;
    bresp_err_o  = err_q;
  end
endmodule

// File: tb/tb_video_ddr_write_ctrl.sv
// tb_video_ddr_write_ctrl: scoreboard bench with FIFO and AXI slave models for the DDR write sequencer
module tb_video_ddr_write_ctrl;
  localparam int DW = 512, AW = 32, FA = 12, BL = 16;
  typedef struct {logic [AW-1:0] addr; logic [7:0] len;} aw_t;
  typedef struct {logic [DW-1:0] data; logic last;} w_t;
  logic rclk = 0, rstn = 1, frame_start = 0, frame_end = 0, rempty = 1, ren, rdy = 0, busy, done, err;
  logic [AW-1:0] base = '0;
  logic [FA-1:0] count = '0;
  logic [DW-1:0] rdata = '0;
  int applied = 0, miscompares = 0, beats = 0, bcnt = 0, done_cnt = 0, done_bcnt = 0, pops = 0, pending_b = 0, wr_idx = 0;
  aw_t exp_aw[$];
  w_t exp_w[$];
  logic [DW-1:0] fifo[$];
  logic [1:0] resp_plan[$];
  bit bp = 0;
  always #5 rclk = ~rclk;
  video_ddr_write_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) axi();
  video_ddr_write_ctrl #(.g_VIDEO_FIFO_AWIDTH(FA), .g_DDR_AXI_DWIDTH(DW), .g_DDR_AXI_AWIDTH(AW), .g_BURST_LEN(BL)) dut (
    .rclk_i(rclk), .rstn_i(rstn), .frame_start_i(frame_start), .frame_end_i(frame_end),
    .frame_base_addr_i(base), .fifo_rdata_count_i(count), .fifo_rempty_i(rempty), .fifo_ren_o(ren),
    .fifo_rdata_i(rdata), .fifo_rdata_rdy_i(rdy), .axi(axi), .busy_o(busy), .frame_done_o(done), .bresp_err_o(err)
  );
  function automatic logic [DW-1:0] word(input int i);
    return {16{32'hC0DE0000 + 32'(i)}};
  endfunction
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask
  task automatic start_frame(input logic [AW-1:0] a);
    base = a;
    frame_start = 1;
    tick(1);
    frame_start = 0;
  endtask
  task automatic end_frame();
    frame_end = 1;
    tick(1);
    frame_end = 0;
  endtask
  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(word(wr_idx));
      exp_w.push_back('{word(wr_idx), ((i + 1) % BL == 0) || (i == n - 1)});
      wr_idx++;
    end
  endtask
  task automatic expect_aw(input logic [AW-1:0] a, input logic [7:0] l);
    exp_aw.push_back('{a, l});
  endtask
  task automatic wait_done(input string name);
    int d0 = done_cnt, t = 0;
    while (done_cnt == d0 && t < 3000) begin
      tick(1);
      t++;
    end
    chk({name, "_done_seen"}, DW'(done_cnt != d0), DW'(1));
    chk({name, "_aw_left"}, DW'(exp_aw.size()), DW'(0));
    chk({name, "_w_left"}, DW'(exp_w.size()), DW'(0));
  endtask
  task automatic wait_beats(input int target);
    int t = 0;
    while (beats < target && t < 2000) begin
      tick(1);
      t++;
    end
    chk("beats_reached", DW'(beats >= target), DW'(1));
  endtask
  // FIFO model: read data valid the cycle after a sampled read enable
  initial begin
    logic ren_s;
    forever begin
      @(negedge rclk);
      ren_s = ren;
      @(posedge rclk);
      #1;
      rdy = 1'b0;
      if (rstn && ren_s) begin
        pops++;
        if (fifo.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL fifo_underflow: got read with 0 words, required none");
        end else begin
          rdata = fifo.pop_front();
          rdy = 1'b1;
        end
      end
      count = FA'(fifo.size());
      rempty = fifo.size() == 0;
    end
  end
  // B responder: one response per completed burst, error codes taken from resp_plan
  initial begin
    logic hs;
    axi.bvalid = 0;
    axi.bresp = 2'b00;
    forever begin
      @(negedge rclk);
      hs = axi.bvalid & axi.bready;
      @(posedge rclk);
      #1;
      if (!rstn || hs) axi.bvalid = 0;
      else if (!axi.bvalid && pending_b > 0) begin
        pending_b--;
        axi.bvalid = 1;
        axi.bresp = resp_plan.size() != 0 ? resp_plan.pop_front() : 2'b00;
      end
    end
  end
  // W backpressure pattern 1-0-0-1 when enabled
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    axi.wready = 1;
    forever begin
      @(posedge rclk);
      #1;
      axi.wready = bp ? pat[k % 4] : 1'b1;
      k++;
    end
  end
  // monitor: pops scoreboard on every handshake and checks stall stability
  initial begin
    aw_t ea;
    w_t ew;
    logic aw_stall = 0, w_stall = 0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0] p_len = '0;
    logic [DW-1:0] p_data = '0;
    forever begin
      @(negedge rclk);
      if (!rstn) begin
        aw_stall = 0;
        w_stall = 0;
      end else begin
        if (aw_stall) begin
          chk("awaddr_hold", DW'(axi.awaddr), DW'(p_addr));
          chk("awlen_hold", DW'(axi.awlen), DW'(p_len));
        end
        if (w_stall) begin
          chk("wvalid_hold", DW'(axi.wvalid), DW'(1));
          chk("wdata_hold", axi.wdata, p_data);
        end
        if (axi.awvalid && axi.awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", DW'(1), DW'(0));
          else begin
            ea = exp_aw.pop_front();
            chk("awaddr", DW'(axi.awaddr), DW'(ea.addr));
            chk("awlen", DW'(axi.awlen), DW'(ea.len));
          end
        end
        if (axi.wvalid && axi.wready) begin
          beats++;
          if (axi.wlast) pending_b++;
          if (exp_w.size() == 0) chk("w_unexpected", DW'(1), DW'(0));
          else begin
            ew = exp_w.pop_front();
            chk("wdata", axi.wdata, ew.data);
            chk("wlast", DW'(axi.wlast), DW'(ew.last));
          end
        end
        if (axi.bvalid && axi.bready) bcnt++;
        if (done) begin
          done_cnt++;
          done_bcnt = bcnt;
        end
        aw_stall = axi.awvalid & !axi.awready;
        p_addr = axi.awaddr;
        p_len = axi.awlen;
        w_stall = axi.wvalid & !axi.wready;
        p_data = axi.wdata;
      end
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, b0, d0, e0;
    axi.awready = 1;
    #2 rstn = 0;
    tick(3);
    chk("rst_awvalid", DW'(axi.awvalid), DW'(0));
    chk("rst_wvalid", DW'(axi.wvalid), DW'(0));
    chk("rst_wlast", DW'(axi.wlast), DW'(0));
    chk("rst_bready", DW'(axi.bready), DW'(0));
    chk("rst_ren", DW'(ren), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_awaddr", DW'(axi.awaddr), DW'(0));
    chk("rst_awlen", DW'(axi.awlen), DW'(0));
    chk("awsize", DW'(axi.awsize), DW'(6));
    chk("awburst", DW'(axi.awburst), DW'(1));
    chk("wstrb", DW'(axi.wstrb), DW'(64'hFFFF_FFFF_FFFF_FFFF));
    rstn = 1;
    tick(2);
    chk("idle_busy", DW'(busy), DW'(0));
    // two full bursts in FIFO order, second at base + 1 KB
    p0 = pops;
    start_frame(32'h1000_0000);
    chk("start_busy", DW'(busy), DW'(1));
    expect_aw(32'h1000_0000, 8'd15);
    expect_aw(32'h1000_0400, 8'd15);
    load(32);
    tick(5);
    end_frame();
    wait_done("full");
    chk("full_pops", DW'(pops - p0), DW'(32));
    chk("full_err", DW'(err), DW'(0));
    chk("full_empty", DW'(rempty), DW'(1));
    chk("full_idle", DW'(busy), DW'(0));
    // W backpressure
    bp = 1;
    p0 = pops;
    start_frame(32'h2000_0000);
    expect_aw(32'h2000_0000, 8'd15);
    load(16);
    tick(5);
    end_frame();
    wait_done("bp");
    chk("bp_pops", DW'(pops - p0), DW'(16));
    bp = 0;
    // 21 words: full burst then a 5-beat flush
    b0 = bcnt;
    d0 = done_cnt;
    start_frame(32'h3000_0000);
    expect_aw(32'h3000_0000, 8'd15);
    expect_aw(32'h3000_0400, 8'd4);
    load(21);
    tick(5);
    end_frame();
    wait_done("flush");
    tick(5);
    chk("flush_b_before_done", DW'(done_bcnt - b0), DW'(2));
    chk("flush_done_once", DW'(done_cnt - d0), DW'(1));
    chk("flush_empty", DW'(rempty), DW'(1));
    chk("flush_count", DW'(count), DW'(0));
    // SLVERR on first burst is sticky until the next frame start
    b0 = bcnt;
    start_frame(32'h4000_0000);
    resp_plan.push_back(2'b10);
    expect_aw(32'h4000_0000, 8'd15);
    expect_aw(32'h4000_0400, 8'd15);
    load(32);
    for (int t = 0; t < 2000 && bcnt == b0; t++) tick(1);
    tick(1);
    chk("err_set", DW'(err), DW'(1));
    tick(5);
    end_frame();
    wait_done("err");
    chk("err_held", DW'(err), DW'(1));
    p0 = pops;
    start_frame(32'h4100_0000);
    chk("err_cleared", DW'(err), DW'(0));
    end_frame();
    wait_done("empty");
    chk("empty_pops", DW'(pops - p0), DW'(0));
    // frame_start during DATA is ignored
    e0 = beats;
    start_frame(32'h5000_0000);
    expect_aw(32'h5000_0000, 8'd15);
    expect_aw(32'h5000_0400, 8'd15);
    load(32);
    wait_beats(e0 + 3);
    start_frame(32'h6000_0000);
    tick(5);
    end_frame();
    wait_done("restart");
    // asynchronous reset after beat 5
    e0 = beats;
    start_frame(32'h7000_0000);
    expect_aw(32'h7000_0000, 8'd15);
    load(16);
    wait_beats(e0 + 5);
    #2 rstn = 0;
    #1;
    chk("arst_awvalid", DW'(axi.awvalid), DW'(0));
    chk("arst_wvalid", DW'(axi.wvalid), DW'(0));
    chk("arst_ren", DW'(ren), DW'(0));
    chk("arst_busy", DW'(busy), DW'(0));
    fifo.delete();
    exp_aw.delete();
    exp_w.delete();
    resp_plan.delete();
    pending_b = 0;
    tick(2);
    rstn = 1;
    tick(3);
    chk("post_rst_busy", DW'(busy), DW'(0));
    chk("post_rst_awvalid", DW'(axi.awvalid), DW'(0));
    chk("post_rst_wvalid", DW'(axi.wvalid), DW'(0));
    // normal operation after reset
    start_frame(32'h8000_0000);
    expect_aw(32'h8000_0000, 8'd15);
    load(16);
    tick(5);
    end_frame();
    wait_done("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
